// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic pipeline register with a 2-entry skid buffer.
// Holds a head (main) entry and a skid entry so in_ready can be a flop
// while still sustaining one payload per cycle. Flush empties the stage
// and drops any same-cycle incoming payload. Two saturating event
// counters (stall, flush) support performance debug.
module pipe_stage_reg #(
    parameter int                 DATA_W = 96,
    parameter logic [DATA_W-1:0]  BUBBLE = DATA_W'({64'b0, 32'h00000013}),
    parameter int                 CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    input  logic              cnt_clr,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_q,  main_d;
    logic [DATA_W-1:0] skid_q,  skid_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

    logic in_fire;
    logic out_fire;

    // Handshake events, using only registered ready/valid.
    assign in_fire  = in_valid  & in_ready_q;
    assign out_fire = out_valid_q & out_ready;

    // Next state and storage: flush wins, otherwise FIFO moves between main and skid.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            unique case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    // Handshake outputs registered from the next state, so neither depends on out_ready combinationally.
    always_comb begin
        in_ready_d  = (state_d != ST_FULL);
        out_valid_d = (state_d != ST_EMPTY);
    end

    // Saturating event counters; clear overrides increment, flush does not touch them.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (out_valid_q && !out_ready && (stall_cnt_q != CNT_MAX)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (flush && (flush_cnt_q != CNT_MAX)) begin
                flush_cnt_d = flush_cnt_q + 1'b1;
            end
        end
    end

    // All state and registered outputs, asynchronously reset to the empty stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_EMPTY;
            // NOTE: payload storage is reset too, so out_data and any later head are BUBBLE, never X.
            main_q      <= BUBBLE;
            skid_q      <= BUBBLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            main_q      <= main_d;
            skid_q      <= skid_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_valid_q ? main_q : BUBBLE;
    assign occupancy = state_q;
    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg: directed stimulus, a queue-based model of
// the stage checked on every falling edge, plus hand-computed literal checks.
module tb_pipe_stage_reg;

    localparam int DATA_W = 96;
    localparam int CNT_W  = 4;
    localparam logic [DATA_W-1:0] BUB = {64'b0, 32'h00000013};
    localparam int CMAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              flush;
    logic              cnt_clr;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg #(.DATA_W(DATA_W), .BUBBLE(BUB), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .flush     (flush),
        .cnt_clr   (cnt_clr),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .flush_cnt (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input logic [7:0] tag, input int idx);
        return {24'h0, tag, 32'(idx), 32'hC0DE_0000 + 32'(idx)};
    endfunction

    // Reference model: a bounded FIFO of capacity 2 plus event counters.
    logic [DATA_W-1:0] mq[$];
    int stall_m;
    int flush_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            stall_m = 0;
            flush_m = 0;
        end else begin
            automatic bit acc = in_valid && (mq.size() < 2);
            automatic bit dlv = (mq.size() > 0) && out_ready;
            automatic bit stl = (mq.size() > 0) && !out_ready;
            if (cnt_clr) begin
                stall_m = 0;
                flush_m = 0;
            end else begin
                if (stl && stall_m < CMAX) stall_m++;
                if (flush && flush_m < CMAX) flush_m++;
            end
            if (flush) begin
                mq.delete();
            end else begin
                if (dlv) void'(mq.pop_front());
                if (acc) mq.push_back(in_data);
            end
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clk) begin
        check("cmp_out_valid", 128'(out_valid), 128'(mq.size() > 0));
        check("cmp_in_ready",  128'(in_ready),  128'(mq.size() < 2));
        check("cmp_occupancy", 128'(occupancy), 128'(mq.size()));
        check("cmp_out_data",  128'(out_data),  128'((mq.size() > 0) ? mq[0] : BUB));
        check("cmp_stall_cnt", 128'(stall_cnt), 128'(stall_m));
        check("cmp_flush_cnt", 128'(flush_cnt), 128'(flush_m));
    end

    // Apply one cycle of inputs just after a falling edge.
    task automatic drive(input logic iv, input logic [DATA_W-1:0] d,
                         input logic ordy, input logic fl, input logic clr);
        @(negedge clk);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        cnt_clr   = clr;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, '0, ordy, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        cnt_clr   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_data", 128'(out_data), 128'(BUB));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        rst_n = 1'b1;

        // Streaming A0..A9 with out_ready held high.
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, mk(8'hA0, i), 1'b1, 1'b0, 1'b0);
            if (i > 0) check("stream_order", 128'(out_data), 128'(mk(8'hA0, i - 1)));
        end
        idle(1'b1);
        check("stream_last", 128'(out_data), 128'(mk(8'hA0, 9)));
        check("stream_no_stall", 128'(stall_cnt), 128'(0));
        idle(1'b1);
        check("stream_drained", 128'(occupancy), 128'(0));

        // Skid: B0 consumed, then downstream stalls for three cycles.
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, mk(8'hB0, 0), 1'b1, 1'b0, 1'b0);
        drive(1'b1, mk(8'hB0, 1), 1'b1, 1'b0, 1'b0);
        check("skid_b0_out", 128'(out_data), 128'(mk(8'hB0, 0)));
        drive(1'b1, mk(8'hB0, 2), 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        idle(1'b1);
        check("skid_occ2", 128'(occupancy), 128'(2));
        check("skid_in_ready0", 128'(in_ready), 128'(0));
        check("skid_stall3", 128'(stall_cnt), 128'(3));
        check("skid_b1_head", 128'(out_data), 128'(mk(8'hB0, 1)));
        idle(1'b1);
        check("skid_b2_next", 128'(out_data), 128'(mk(8'hB0, 2)));
        check("skid_in_ready1", 128'(in_ready), 128'(1));
        idle(1'b1);
        check("skid_empty", 128'(out_valid), 128'(0));

        // Flush while FULL: C0 delivered, C1 discarded.
        drive(1'b0, '0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, mk(8'hC0, 0), 1'b0, 1'b0, 1'b0);
        drive(1'b1, mk(8'hC0, 1), 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        check("flush_pre_full", 128'(occupancy), 128'(2));
        drive(1'b1, mk(8'hD0, 0), 1'b1, 1'b0, 1'b0);
        check("flush_occ0", 128'(occupancy), 128'(0));
        check("flush_bubble", 128'(out_data), 128'(BUB));
        check("flush_cnt1", 128'(flush_cnt), 128'(1));
        check("flush_ready", 128'(in_ready), 128'(1));

        // Flush with in_fire in ONE: D0 delivered, E0 never appears.
        drive(1'b1, mk(8'hE0, 0), 1'b1, 1'b1, 1'b0);
        check("d0_after_flush", 128'(out_data), 128'(mk(8'hD0, 0)));
        idle(1'b1);
        check("flush_in_drop", 128'(out_valid), 128'(0));
        idle(1'b1);
        check("flush_in_drop2", 128'(out_data), 128'(BUB));
        check("flush_cnt2", 128'(flush_cnt), 128'(2));

        // Saturation: 20 stall cycles, then clear during a stall.
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, mk(8'hF0, 0), 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) idle(1'b0);
        check("stall_sat15", 128'(stall_cnt), 128'(15));
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        check("stall_clr", 128'(stall_cnt), 128'(0));
        idle(1'b1);

        // Flush counter saturation.
        for (int i = 0; i < 18; i++) drive(1'b0, '0, 1'b1, 1'b1, 1'b0);
        idle(1'b1);
        check("flush_sat15", 128'(flush_cnt), 128'(15));

        // Asynchronous reset while FULL.
        drive(1'b1, mk(8'h60, 0), 1'b0, 1'b0, 1'b0);
        drive(1'b1, mk(8'h60, 1), 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        check("prereset_full", 128'(occupancy), 128'(2));
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 128'(out_valid), 128'(0));
        check("arst_out_data",  128'(out_data),  128'(BUB));
        check("arst_in_ready",  128'(in_ready),  128'(1));
        check("arst_occupancy", 128'(occupancy), 128'(0));
        check("arst_stall",     128'(stall_cnt), 128'(0));
        check("arst_flush",     128'(flush_cnt), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, mk(8'h70, 0), 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        check("post_reset_data", 128'(out_data), 128'(mk(8'h70, 0)));
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline register that generalises the fixed IF/ID stage register. It has a configurable payload width, a configurable bubble value and a valid/ready handshake. A 2-entry skid buffer lets the ready signal be registered without losing throughput. It drops in between any two core stages (IF/ID, ID/EX, ...), keeps branch-flush semantics, and adds stall/flush event counters for performance debug.

## Interface
Parameters:
- DATA_W, 96, payload width (e.g. {pc, pc_plus_4, instruction})
- BUBBLE, {64'b0, 32'h00000013}, DATA_W-bit value driven on out_data when no valid entry (NOP)
- CNT_W, 16, width of each saturating event counter

Ports:
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream has payload
- in_ready  output  1  stage can accept; registered (depends only on state)
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  stage holds valid payload
- out_ready  input  1  downstream accepts
- out_data  output  DATA_W  head payload, or BUBBLE when out_valid=0
- flush  input  1  discard all held and incoming payload (branch taken)
- cnt_clr  input  1  synchronous clear of both counters
- occupancy  output  2  entries held: 0, 1 or 2
- stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
- flush_cnt  output  CNT_W  cycles with flush=1, saturating

## Operation
- Storage: main entry (head) and skid entry. States are EMPTY (0), ONE (main valid) and FULL (main+skid valid). occupancy encodes the state.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != FULL). out_valid = (state != EMPTY). out_data = main_data if out_valid, else BUBBLE.
- Transitions when flush=0:
  - EMPTY: in_fire -> ONE, main<=in_data.
  - ONE: in_fire & out_fire -> ONE, main<=in_data. in_fire only -> FULL, skid<=in_data. out_fire only -> EMPTY. Otherwise hold.
  - FULL: out_fire -> ONE, main<=skid. Otherwise hold. in_fire is impossible (in_ready=0).
- flush=1 has priority over all transitions:
  - Next state is EMPTY; main and skid data <= BUBBLE.
  - A same-cycle out_fire counts as consumed by downstream.
  - A same-cycle in_fire is discarded: the upstream handshake completes and the data is dropped.
- Order is strictly FIFO. No payload is duplicated or dropped except by flush.
- Counters:
  - stall_cnt increments when out_valid & !out_ready. flush_cnt increments when flush=1.
  - Both saturate at 2^CNT_W-1 with no wrap.
  - cnt_clr forces both to 0 and overrides increment in the same cycle.
  - Counters are unaffected by flush.
- Reset (async, any time, including mid-transfer): state EMPTY, main/skid data = BUBBLE, in_ready=1, out_valid=0, out_data=BUBBLE, occupancy=0, stall_cnt=0, flush_cnt=0.

## Timing
- Latency: payload accepted at edge N appears on out_data/out_valid after edge N, i.e. visible in cycle N+1.
- Throughput: 1 payload per cycle sustained when out_ready is held 1.
- in_ready, out_valid, out_data and occupancy are register outputs or BUBBLE-muxed from registers. There is no combinational path from out_ready to in_ready.
- After a downstream stall begins, one more payload is absorbed (skid). in_ready drops the cycle after the state reaches FULL. It rises the cycle after the first out_fire in FULL.
- flush at edge N: out_valid=0, in_ready=1, out_data=BUBBLE from cycle N+1. New payload is accepted in cycle N+1.
- Counter values reflect events up to and including the previous edge.

## Test plan
- Reset: drive rst_n=0 mid-stream with FULL state → immediately out_valid=0, out_data=BUBBLE (0x...00000013), in_ready=1, occupancy=0, counters 0.
- Streaming: send A0..A9 back-to-back with out_ready=1 → out_data A0..A9 in order, one per cycle, first at 1 cycle after accept, stall_cnt=0.
- Skid: stream B0,B1,B2 and drop out_ready after B0 appears for 3 cycles → B1 held in main, B2 in skid, occupancy=2, in_ready=0, stall_cnt=3. Raise out_ready → B1 then B2 output with no loss.
- Flush: in FULL with in_valid=0, assert flush one cycle with out_ready=1 → next cycle occupancy=0, out_data=BUBBLE, flush_cnt=1. The entry at out_data in the flush cycle counts as delivered, the other is discarded.
- Flush with in_fire in ONE state → incoming payload is never output, state EMPTY.
- Saturation: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles → stall_cnt=15. Assert cnt_clr together with a stall cycle → stall_cnt=0.
